bimodal_pht: RTL and testbench

BIMODAL_PHT -- requirements
Module: bimodal_pht

---
 rtl/bpu_pkg.sv | 25 ++
 rtl/sat_cnt_update.sv | 20 ++
 rtl/bimodal_pht.sv | 153 +++++++++++++++
 tb/tb_bimodal_pht.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the bimodal branch predictor: 2-bit counter type,
// its four encodings, the FSM state enum and a debug probe struct.
package bpu_pkg;

    typedef logic [1:0] cnt2_t;

    localparam cnt2_t CNT_SNT = 2'b00;  // strong not-taken
    localparam cnt2_t CNT_WNT = 2'b01;  // weak not-taken (init value)
    localparam cnt2_t CNT_WT  = 2'b10;  // weak taken
    localparam cnt2_t CNT_ST  = 2'b11;  // strong taken

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pht_state_t;

    // Snapshot of the control state, exposed as one bundle for probing.
    typedef struct packed {
        pht_state_t state;
        logic       init_last;
        logic       pred_accept;
        logic       upd_fire;
    } pht_dbg_t;

endpackage

// File: rtl/sat_cnt_update.sv
// Two-bit saturating counter step: +1 on taken (max 11), -1 on not-taken (min 00).
module sat_cnt_update
    import bpu_pkg::*;
(
    input  cnt2_t count,
    input  logic  taken,
    output cnt2_t next_count
);

    // Step the counter toward the resolved direction, clamping at the ends.
    always_comb begin
        next_count = count;
        if (taken) begin
            if (count != CNT_ST) next_count = cnt2_t'(count + 2'd1);
        end else begin
            if (count != CNT_SNT) next_count = cnt2_t'(count - 2'd1);
        end
    end

endmodule

// File: rtl/bimodal_pht.sv
// Bimodal pattern history table: a flat array of 2-bit counters indexed by
// pc[IDX_W+1:2]. After reset every entry is rewritten to weak-NT, one per
// cycle, before requests are accepted. Predictions push a counter snapshot
// to an external FIFO; resolved branches pop it (in program order) and use
// the snapshot as the base for the saturating update.
//
// Predict handshake: a request is taken when i_pred_valid and o_pred_ready
// are both high in the same cycle; i_pred_valid without o_pred_ready is
// simply ignored (no holding or replay), and o_pred_ready never depends on
// i_pred_valid. The result appears one cycle later on o_pred_valid for a
// single cycle, with no back-pressure on the result side.
module bimodal_pht
    import bpu_pkg::*;
#(
    parameter int PHT_DEPTH = 64,
    parameter int PC_WIDTH  = 32
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_pred_valid,
    input  logic [PC_WIDTH-1:0] i_pred_pc,
    output logic                o_pred_ready,
    output logic                o_pred_valid,
    output logic                o_pred_taken,
    output logic                o_fifo_write,
    output logic [1:0]          o_fifo_wrcnt,
    input  logic                i_fifo_full,
    input  logic                i_upd_valid,
    input  logic [PC_WIDTH-1:0] i_upd_pc,
    input  logic                i_upd_taken,
    output logic                o_fifo_read,
    input  logic [1:0]          i_fifo_rdcnt,
    input  logic                i_fifo_miss,
    output logic                o_init_done,
    output logic [7:0]          o_miss_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    pht_state_t       state, state_nxt;
    logic [IDX_W-1:0] init_idx, init_idx_nxt;
    logic             init_last;
    logic             run;

    logic [IDX_W-1:0] pred_idx, upd_idx;
    logic             pred_accept, upd_fire;
    cnt2_t            upd_base, upd_next, pred_cnt;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    cnt2_t            wr_data;

    cnt2_t            pht [PHT_DEPTH];

    // Only the index bits of the PCs select an entry; the rest are don't-care.
    logic             unused_pc_bits;
    // Probe point for bound checkers; not read by the logic.
    pht_dbg_t         dbg_unused;

    assign unused_pc_bits = ^{i_pred_pc[PC_WIDTH-1:IDX_W+2], i_pred_pc[1:0],
                              i_upd_pc[PC_WIDTH-1:IDX_W+2], i_upd_pc[1:0]};

    assign pred_idx  = i_pred_pc[IDX_W+1:2];
    assign upd_idx   = i_upd_pc[IDX_W+1:2];
    assign run       = (state == ST_RUN);
    assign init_last = (init_idx == IDX_W'(PHT_DEPTH - 1));

    // FSM register: INIT walks the table, RUN is terminal until reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nxt;
            init_idx <= init_idx_nxt;
        end
    end

    // FSM next state: advance the init index each cycle, leave INIT after the last entry.
    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        case (state)
            ST_INIT: begin
                init_idx_nxt = init_idx + IDX_W'(1);
                if (init_last) state_nxt = ST_RUN;
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign o_init_done  = run;
    assign o_pred_ready = run & ~i_fifo_full;
    assign pred_accept  = i_pred_valid & o_pred_ready;
    assign upd_fire     = run & i_upd_valid;
    assign o_fifo_read  = upd_fire & ~i_fifo_miss;

    // Update path: the FIFO snapshot is the base unless the FIFO ran dry.
    assign upd_base = i_fifo_miss ? pht[upd_idx] : i_fifo_rdcnt;

    sat_cnt_update u_sat (
        .count      (upd_base),
        .taken      (i_upd_taken),
        .next_count (upd_next)
    );

    // Predict read with bypass from a same-cycle update to the same entry.
    always_comb begin
        pred_cnt = pht[pred_idx];
        if (upd_fire && (upd_idx == pred_idx)) pred_cnt = upd_next;
    end

    assign o_fifo_write = pred_accept;
    assign o_fifo_wrcnt = pred_accept ? pred_cnt : CNT_SNT;

    // Single write port: init sweep has the port during INIT, updates during RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_idx;
        wr_data = CNT_WNT;
        if (state == ST_INIT) begin
            wr_en = 1'b1;
        end else if (upd_fire) begin
            wr_en   = 1'b1;
            wr_idx  = upd_idx;
            wr_data = upd_next;
        end
    end

    // Counter table storage; no reset, INIT rewrites every entry.
    always_ff @(posedge i_clk) begin
        if (wr_en) pht[wr_idx] <= wr_data;
    end

    // Registered prediction result and saturating miss counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_pred_valid <= 1'b0;
            o_pred_taken <= 1'b0;
            o_miss_cnt   <= 8'd0;
        end else begin
            o_pred_valid <= pred_accept;
            if (pred_accept) o_pred_taken <= pred_cnt[1];
            if (upd_fire && i_fifo_miss && (o_miss_cnt != 8'hFF))
                o_miss_cnt <= o_miss_cnt + 8'd1;
        end
    end

    assign dbg_unused = '{state: state, init_last: init_last,
                          pred_accept: pred_accept, upd_fire: upd_fire};

endmodule

// File: tb/tb_bimodal_pht.sv
// Bench for bimodal_pht: directed scenarios followed by randomized traffic,
// all checked against a counter-array reference model.
module tb_bimodal_pht;

  localparam int DEPTH = 64;
  localparam int PCW   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_rstn;
  logic           i_pred_valid;
  logic [PCW-1:0] i_pred_pc;
  logic           o_pred_ready;
  logic           o_pred_valid;
  logic           o_pred_taken;
  logic           o_fifo_write;
  logic [1:0]     o_fifo_wrcnt;
  logic           i_fifo_full;
  logic           i_upd_valid;
  logic [PCW-1:0] i_upd_pc;
  logic           i_upd_taken;
  logic           o_fifo_read;
  logic [1:0]     i_fifo_rdcnt;
  logic           i_fifo_miss;
  logic           o_init_done;
  logic [7:0]     o_miss_cnt;

  bimodal_pht #(.PHT_DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .i_clk        (clk),
    .i_rstn       (i_rstn),
    .i_pred_valid (i_pred_valid),
    .i_pred_pc    (i_pred_pc),
    .o_pred_ready (o_pred_ready),
    .o_pred_valid (o_pred_valid),
    .o_pred_taken (o_pred_taken),
    .o_fifo_write (o_fifo_write),
    .o_fifo_wrcnt (o_fifo_wrcnt),
    .i_fifo_full  (i_fifo_full),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .o_fifo_read  (o_fifo_read),
    .i_fifo_rdcnt (i_fifo_rdcnt),
    .i_fifo_miss  (i_fifo_miss),
    .o_init_done  (o_init_done),
    .o_miss_cnt   (o_miss_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;

  int   m_pht [DEPTH];
  int   m_miss;
  bit   m_run;
  int   m_init;
  bit   m_pv;
  logic [0:0] exp_q[$];

  // values sampled in the last cycle, for directed constant checks
  logic       s_ready, s_wr, s_rd;
  logic [1:0] s_wrcnt;
  logic       r_pv, r_pt, r_done;
  logic [7:0] r_miss;

  int fq[$];  // bench-side counter FIFO used in the random phase

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_step(input int base, input bit taken);
    if (taken) return (base >= 3) ? 3 : base + 1;
    return (base <= 0) ? 0 : base - 1;
  endfunction

  function automatic logic [31:0] mk_pc();
    logic [31:0] r;
    r = $urandom();
    r[7:2] = 6'($urandom_range(0, 7));
    return r;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, check combinational outputs, step
  // the model on the posedge, then check registered outputs.
  task automatic cycle(input logic pv, input logic [31:0] ppc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic full, input logic miss, input logic [1:0] rdcnt);
    int  uidx, pidx, nxt, pcnt;
    bit  acc, upd;
    @(negedge clk);
    i_pred_valid = pv;  i_pred_pc = ppc;
    i_upd_valid  = uv;  i_upd_pc  = upc;  i_upd_taken = ut;
    i_fifo_full  = full; i_fifo_miss = miss; i_fifo_rdcnt = rdcnt;

    acc  = pv && m_run && !full;
    upd  = uv && m_run;
    uidx = int'(upc[7:2]);
    pidx = int'(ppc[7:2]);
    nxt  = 0;
    if (upd) nxt = sat_step(miss ? m_pht[uidx] : int'(rdcnt), ut);
    pcnt = (upd && uidx == pidx) ? nxt : m_pht[pidx];

    #2;
    s_ready = o_pred_ready; s_wr = o_fifo_write; s_rd = o_fifo_read; s_wrcnt = o_fifo_wrcnt;
    check("pred_ready", 32'(o_pred_ready), 32'(m_run && !full));
    check("fifo_write", 32'(o_fifo_write), 32'(acc));
    check("fifo_read",  32'(o_fifo_read),  32'(upd && !miss));
    if (acc) check("fifo_wrcnt", 32'(o_fifo_wrcnt), 32'(pcnt));

    @(posedge clk);
    if (upd) m_pht[uidx] = nxt;
    if (upd && miss && m_miss < 255) m_miss++;
    if (acc) exp_q.push_back(1'(pcnt >> 1));
    m_pv = acc;
    if (!m_run) begin
      m_init++;
      if (m_init == DEPTH) begin
        m_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
      end
    end

    #1;
    r_pv = o_pred_valid; r_pt = o_pred_taken; r_done = o_init_done; r_miss = o_miss_cnt;
    check("pred_valid", 32'(o_pred_valid), 32'(m_pv));
    if (m_pv && exp_q.size() > 0) check("pred_taken", 32'(o_pred_taken), 32'(exp_q.pop_front()));
    check("miss_cnt",  32'(o_miss_cnt),  32'(m_miss));
    check("init_done", 32'(o_init_done), 32'(m_run));
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Assert reset mid-cycle with active inputs, check outputs, release after a posedge.
  task automatic do_reset();
    @(negedge clk);
    i_pred_valid = 1'b1; i_pred_pc = 32'h14; i_upd_valid = 1'b1; i_upd_pc = 32'h14;
    i_upd_taken = 1'b1; i_fifo_full = 1'b0; i_fifo_miss = 1'b1; i_fifo_rdcnt = 2'd0;
    #3 i_rstn = 1'b0;
    #1;
    check("rst_pred_valid", 32'(o_pred_valid), 32'd0);
    check("rst_pred_taken", 32'(o_pred_taken), 32'd0);
    check("rst_miss_cnt",   32'(o_miss_cnt),   32'd0);
    check("rst_init_done",  32'(o_init_done),  32'd0);
    check("rst_pred_ready", 32'(o_pred_ready), 32'd0);
    check("rst_fifo_write", 32'(o_fifo_write), 32'd0);
    check("rst_fifo_read",  32'(o_fifo_read),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_init_done", 32'(o_init_done), 32'd0);
    check("rst_hold_pred_valid", 32'(o_pred_valid), 32'd0);
    #2 i_rstn = 1'b1;
    m_run = 1'b0; m_init = 0; m_miss = 0; m_pv = 1'b0;
    exp_q.delete();
    fq.delete();
  endtask

  task automatic random_cycle();
    logic full, miss, pv, uv, ut;
    logic [1:0] rdcnt;
    full  = (fq.size() >= 4) || ($urandom_range(0, 9) == 0);
    miss  = (fq.size() == 0);
    rdcnt = miss ? 2'($urandom_range(0, 3)) : 2'(fq[0]);
    pv    = 1'($urandom_range(0, 1));
    uv    = 1'($urandom_range(0, 1));
    ut    = 1'($urandom_range(0, 1));
    cycle(pv, mk_pc(), uv, mk_pc(), ut, full, miss, rdcnt);
    if (s_rd && fq.size() > 0) void'(fq.pop_front());
    if (s_wr) fq.push_back(int'(s_wrcnt));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rstn = 1'b0;
    i_pred_valid = 1'b0; i_pred_pc = '0; i_upd_valid = 1'b0; i_upd_pc = '0;
    i_upd_taken = 1'b0; i_fifo_full = 1'b0; i_fifo_miss = 1'b0; i_fifo_rdcnt = 2'd0;
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 0;
    m_miss = 0; m_run = 1'b0; m_init = 0; m_pv = 1'b0;

    do_reset();

    // init takes exactly DEPTH cycles
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      if (i == DEPTH - 2) check("init_not_done_63", 32'(r_done), 32'd0);
    end
    check("init_done_64", 32'(r_done), 32'd1);

    // first predict after init sees weak-NT
    cycle(1'b1, 32'hDEAD_BEE8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("first_wrcnt", 32'(s_wrcnt), 32'd1);
    check("first_taken", 32'(r_pt), 32'd0);

    // three taken updates from FIFO 01,10,11 at pc 0x40
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 2'(k));
      check("upd_fifo_read", 32'(s_rd), 32'd1);
    end
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("entry16_st", 32'(s_wrcnt), 32'd3);
    check("miss_zero", 32'(r_miss), 32'd0);

    // drive entry 16 to 00, then a missed not-taken update keeps it there
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 2'd1);
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 2'd3);
    check("miss_no_read", 32'(s_rd), 32'd0);
    check("miss_one", 32'(r_miss), 32'd1);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("entry16_snt", 32'(s_wrcnt), 32'd0);
    for (int k = 0; k < 300; k++)
      cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
    check("miss_sat", 32'(r_miss), 32'd255);

    // FIFO full blocks predict
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("full_ready", 32'(s_ready), 32'd0);
    check("full_write", 32'(s_wr), 32'd0);
    check("full_pv", 32'(r_pv), 32'd0);

    // same-index bypass
    cycle(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 2'd1);
    check("bypass_wrcnt", 32'(s_wrcnt), 32'd2);
    check("bypass_taken", 32'(r_pt), 32'd1);

    // different indices in one cycle
    cycle(1'b1, 32'h84, 1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 2'd3);
    cycle(1'b1, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("diff_idx_upd", 32'(s_wrcnt), 32'd3);

    // write entry 5 to 11, reset in RUN, init restores 01
    cycle(1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 2'd2);
    cycle(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("entry5_st", 32'(s_wrcnt), 32'd3);
    do_reset();
    repeat (DEPTH) idle();
    cycle(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("entry5_reinit", 32'(s_wrcnt), 32'd1);

    // random traffic, including a reset part way through INIT
    repeat (300) random_cycle();
    do_reset();
    repeat (20) random_cycle();
    do_reset();
    repeat (500) random_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
